ip_codma_rd_engine: RTL and testbench

- Parametrised read engine for the codma datapath; successor to the fixed 8-word read machine.
- Issues one bus read request of programmable length and collects returned beats into a word buffer.
- Bus width, word width and buffer depth are configurable; adds a grant timeout, length checking, and done/error reporting with an error code.
- Sits between the DMA control FSM (start/stop, length, address) and the shared memory bus.

---
 rtl/ip_codma_rd_engine.sv | 174 +++++++++++++++++
 tb/tb_ip_codma_rd_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_rd_engine.sv
// ip_codma_rd_engine
// Parametrised codma read engine. It issues one bus read request of
// programmable length and packs the returned beats into a word buffer.
// It reports completion with done_o, and failures with error_o plus a
// two-bit error code (bus error, grant timeout or bad length).

module ip_codma_rd_engine #(
   parameter int BUS_W     = 64,
   parameter int WORD_W    = 32,
   parameter int MAX_WORDS = 8,
   parameter int TIMEOUT   = 255,
   localparam int WPB      = BUS_W / WORD_W,
   localparam int LW       = $clog2(MAX_WORDS + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   input  logic                          stop_i,
   input  logic [31:0]                   addr_i,
   input  logic [LW-1:0]                 len_words_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          error_o,
   output logic [1:0]                    err_code_o,
   output logic [MAX_WORDS*WORD_W-1:0]   data_o,
   output logic [LW-1:0]                 word_count_o,
   output logic                          bus_req_o,
   output logic [31:0]                   bus_addr_o,
   output logic [LW-1:0]                 bus_beats_o,
   input  logic                          bus_grant_i,
   input  logic                          bus_rvalid_i,
   input  logic [BUS_W-1:0]              bus_rdata_i,
   input  logic                          bus_error_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ASK  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BUS     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_LENGTH  = 2'd3;

   // Word index width into the buffer and width of the grant timeout counter.
   localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [2:0]                          state;
   logic [2:0]                          next_state;
   logic [LW-1:0]                       len_words;
   logic [TW-1:0]                       timeout_cnt;
   logic [MAX_WORDS-1:0][WORD_W-1:0]    word_buf;
   logic [LW-1:0]                       remaining;
   logic [LW-1:0]                       take;
   logic [1:0]                          next_code;
   logic                                bad_len;
   logic                                timeout_hit;
   logic                                accept;
   logic                                store;

   assign data_o = word_buf;

   // Next-state decode, including stop/error/timeout priority and beat acceptance.
   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (which would infer a latch).
   always_comb begin
      next_state  = state;
      next_code   = err_code_o;
      accept      = 1'b0;
      store       = 1'b0;
      remaining   = len_words - word_count_o;
      take        = (int'(remaining) < WPB) ? remaining : LW'(WPB);
      bad_len     = (len_words_i == '0) || (int'(len_words_i) > MAX_WORDS);
      timeout_hit = (TIMEOUT != 0) && (timeout_cnt == TW'(TIMEOUT - 1));

      if (stop_i) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  if (bad_len) begin
                     next_state = S_ERR;
                     next_code  = ERR_LENGTH;
                  end else begin
                     next_state = S_ASK;
                     next_code  = ERR_NONE;
                     accept     = 1'b1;
                  end
               end
            end
            S_ASK: begin
               if (bus_error_i) begin
                  next_state = S_ERR;
                  next_code  = ERR_BUS;
               end else if (!bus_grant_i && timeout_hit) begin
                  next_state = S_ERR;
                  next_code  = ERR_TIMEOUT;
               end else if (bus_grant_i) begin
                  next_state = S_DATA;
               end
            end
            S_DATA: begin
               if (bus_error_i) begin
                  next_state = S_ERR;
                  next_code  = ERR_BUS;
               end else if (bus_rvalid_i) begin
                  store = 1'b1;
                  if (word_count_o + take == len_words) begin
                     next_state = S_DONE;
                  end
               end
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
         endcase
      end
   end

   // Control state, registered status outputs and transfer parameters.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state       <= S_IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         error_o     <= 1'b0;
         bus_req_o   <= 1'b0;
         err_code_o  <= ERR_NONE;
         bus_addr_o  <= '0;
         bus_beats_o <= '0;
         len_words   <= '0;
         timeout_cnt <= '0;
      end else begin
         state      <= next_state;
         busy_o     <= (next_state != S_IDLE);
         done_o     <= (next_state == S_DONE);
         error_o    <= (next_state == S_ERR);
         bus_req_o  <= (next_state == S_ASK) || (next_state == S_DATA);
         err_code_o <= next_code;
         if (accept) begin
            bus_addr_o  <= addr_i;
            len_words   <= len_words_i;
            bus_beats_o <= LW'((int'(len_words_i) + WPB - 1) / WPB);
            timeout_cnt <= '0;
         end else if (state == S_ASK && !bus_grant_i) begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end
      end
   end

   // Word buffer and stored-word counter; cleared on an accepted start only.
   // NOTE: the buffer is reset because its contents are visible on data_o and must read as zero after reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         word_buf     <= '0;
         word_count_o <= '0;
      end else if (accept) begin
         word_buf     <= '0;
         word_count_o <= '0;
      end else if (store) begin
         for (int j = 0; j < WPB; j++) begin
            if (j < int'(take)) begin
               word_buf[IW'(word_count_o + LW'(j))] <= bus_rdata_i[j*WORD_W +: WORD_W];
            end
         end
         word_count_o <= word_count_o + take;
      end
   end

endmodule

// File: tb/tb_ip_codma_rd_engine.sv
// tb_ip_codma_rd_engine
// Directed bench for ip_codma_rd_engine with BUS_W=64, WORD_W=32,
// MAX_WORDS=8, TIMEOUT=4. Inputs are driven and outputs observed 1 ns
// after each rising edge.

module tb_ip_codma_rd_engine;

   localparam int LW = 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          start_i;
   logic          stop_i;
   logic [31:0]   addr_i;
   logic [LW-1:0] len_words_i;
   logic          busy_o;
   logic          done_o;
   logic          error_o;
   logic [1:0]    err_code_o;
   logic [255:0]  data_o;
   logic [LW-1:0] word_count_o;
   logic          bus_req_o;
   logic [31:0]   bus_addr_o;
   logic [LW-1:0] bus_beats_o;
   logic          bus_grant_i;
   logic          bus_rvalid_i;
   logic [63:0]   bus_rdata_i;
   logic          bus_error_i;

   int checks = 0;
   int errors = 0;
   logic [255:0] exp_data;

   ip_codma_rd_engine #(
      .BUS_W(64), .WORD_W(32), .MAX_WORDS(8), .TIMEOUT(4)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
      .addr_i(addr_i), .len_words_i(len_words_i), .busy_o(busy_o), .done_o(done_o),
      .error_o(error_o), .err_code_o(err_code_o), .data_o(data_o),
      .word_count_o(word_count_o), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
      .bus_beats_o(bus_beats_o), .bus_grant_i(bus_grant_i), .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i(bus_rdata_i), .bus_error_i(bus_error_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      reset_n_i    = 1'b0;
      start_i      = 1'b0;
      stop_i       = 1'b0;
      addr_i       = '0;
      len_words_i  = '0;
      bus_grant_i  = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      bus_error_i  = 1'b0;
      #2;
      check("rst_busy", busy_o, 0);
      check("rst_req", bus_req_o, 0);
      check("rst_data", data_o, 0);
      check("rst_cnt", word_count_o, 0);
      check("rst_code", err_code_o, 0);
      check("rst_addr", bus_addr_o, 0);
      check("rst_beats", bus_beats_o, 0);
      #10 reset_n_i = 1'b1;
      tick();

      // Full 8-word read, grant two cycles after request.
      addr_i = 32'h0000_1000; len_words_i = 4'd8; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t1_req", bus_req_o, 1);
      check("t1_busy", busy_o, 1);
      check("t1_beats", bus_beats_o, 4);
      check("t1_addr", bus_addr_o, 32'h0000_1000);
      tick();
      check("t1_req_wait", bus_req_o, 1);
      // A beat during the grant cycle must be ignored.
      bus_grant_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      bus_grant_i = 1'b0;
      check("t1_grant_beat_ignored", word_count_o, 0);
      for (int i = 0; i < 4; i++) begin
         bus_rvalid_i = 1'b1;
         bus_rdata_i  = {32'(2*i + 1), 32'(2*i)};
         tick();
      end
      bus_rvalid_i = 1'b0;
      check("t1_done", done_o, 1);
      check("t1_req_done", bus_req_o, 0);
      check("t1_cnt", word_count_o, 8);
      tick();
      check("t1_done_clr", done_o, 0);
      check("t1_idle", busy_o, 0);
      for (int i = 0; i < 8; i++) exp_data[i*32 +: 32] = 32'(i);
      check("t1_data", data_o, exp_data);

      // Short read of 3 words; the excess word of the final beat is discarded.
      len_words_i = 4'd3; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t2_beats", bus_beats_o, 2);
      check("t2_cleared", data_o, 0);
      bus_grant_i = 1'b1;
      tick();
      bus_grant_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = {32'd1, 32'd0};
      tick();
      check("t2_cnt_mid", word_count_o, 2);
      bus_rdata_i = {32'hDEAD, 32'd2};
      tick();
      bus_rvalid_i = 1'b0;
      check("t2_done", done_o, 1);
      check("t2_cnt", word_count_o, 3);
      tick();
      check("t2_done_once", done_o, 0);
      exp_data = '0;
      exp_data[31:0] = 32'd0; exp_data[63:32] = 32'd1; exp_data[95:64] = 32'd2;
      check("t2_data", data_o, exp_data);

      // Grant never arrives: timeout after the 4th ASK cycle.
      len_words_i = 4'd4; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      tick();
      check("t3_no_err_yet", error_o, 0);
      check("t3_req_4th", bus_req_o, 1);
      tick();
      check("t3_error", error_o, 1);
      check("t3_code", err_code_o, 2);
      check("t3_req_low", bus_req_o, 0);
      tick();
      check("t3_err_clr", error_o, 0);
      check("t3_code_hold", err_code_o, 2);
      check("t3_idle", busy_o, 0);

      // Bus error alongside the 2nd beat.
      len_words_i = 4'd8; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t4_code_clr", err_code_o, 0);
      bus_grant_i = 1'b1;
      tick();
      bus_grant_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = {32'h11, 32'h10};
      tick();
      bus_error_i = 1'b1; bus_rdata_i = {32'h13, 32'h12};
      tick();
      bus_error_i = 1'b0; bus_rvalid_i = 1'b0;
      check("t4_error", error_o, 1);
      check("t4_code", err_code_o, 1);
      check("t4_cnt", word_count_o, 2);
      check("t4_no_done", done_o, 0);
      tick();
      check("t4_no_done_after", done_o, 0);

      // Bad lengths 0 and 9.
      len_words_i = 4'd0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t5_len0_err", error_o, 1);
      check("t5_len0_code", err_code_o, 3);
      check("t5_len0_req", bus_req_o, 0);
      tick();
      check("t5_len0_clr", error_o, 0);
      len_words_i = 4'd9; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t5_len9_err", error_o, 1);
      check("t5_len9_code", err_code_o, 3);
      check("t5_len9_req", bus_req_o, 0);
      tick();

      // Stop after the first beat of four, then a fresh start.
      len_words_i = 4'd8; start_i = 1'b1;
      tick();
      start_i = 1'b0; bus_grant_i = 1'b1;
      tick();
      bus_grant_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = {32'h21, 32'h20};
      tick();
      bus_rvalid_i = 1'b0; stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check("t6_idle", busy_o, 0);
      check("t6_req", bus_req_o, 0);
      check("t6_pulses", {done_o, error_o}, 0);
      check("t6_cnt", word_count_o, 2);
      len_words_i = 4'd8; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t6_restart_busy", busy_o, 1);
      check("t6_restart_cnt", word_count_o, 0);
      bus_grant_i = 1'b1;
      tick();
      bus_grant_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = {32'h31, 32'h30};
      tick();
      bus_rvalid_i = 1'b0;
      check("t6_data_cnt", word_count_o, 2);

      // Asynchronous reset in the middle of DATA.
      reset_n_i = 1'b0;
      #1;
      check("t7_req", bus_req_o, 0);
      check("t7_busy", busy_o, 0);
      check("t7_cnt", word_count_o, 0);
      check("t7_data", data_o, 0);
      check("t7_addr", bus_addr_o, 0);
      check("t7_beats", bus_beats_o, 0);
      reset_n_i = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
